// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-capture path: widths, the Z buffer
// entry layout and the condition-flag helpers reused by condition-code logic.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             wide;
    logic             zero;
    logic             neg;
  } z_entry_t;

  // A narrow result is judged on the low word alone; alu_hi is meaningless then.
  function automatic logic flag_zero(input logic [WIDTH-1:0] lo,
                                     input logic [WIDTH-1:0] hi,
                                     input logic             wide);
    return (lo == '0) && (!wide || (hi == '0));
  endfunction

  function automatic logic flag_neg(input logic [WIDTH-1:0] lo,
                                    input logic [WIDTH-1:0] hi,
                                    input logic             wide);
    return wide ? hi[WIDTH-1] : lo[WIDTH-1];
  endfunction

endpackage

// File: rtl/z_flag_gen.sv
// Zero/negative flag derivation for an incoming ALU result, evaluated on the
// push path so the flags are stored alongside the data.
module z_flag_gen
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             wide,
  output logic             zero,
  output logic             neg
);

  assign zero = flag_zero(lo, hi, wide);
  assign neg  = flag_neg(lo, hi, wide);

endmodule

// File: rtl/alu_z_stage.sv
// Two-entry Z buffer between the ALU function units and the bus-drive logic;
// captures ZLow/ZHigh pairs with flags and presents the oldest over valid/ready.
module alu_z_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic             alu_wide,
  input  logic             flush,
  output logic             z_valid,
  input  logic             z_ready,
  output logic [WIDTH-1:0] zlo_out,
  output logic [WIDTH-1:0] zhi_out,
  output logic             z_zero,
  output logic             z_neg,
  output logic [1:0]       z_count
);

  z_entry_t   mem [DEPTH];
  z_entry_t   new_entry;
  z_entry_t   head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       in_zero;
  logic       in_neg;

  z_flag_gen u_flag (
    .lo   (alu_lo),
    .hi   (alu_hi),
    .wide (alu_wide),
    .zero (in_zero),
    .neg  (in_neg)
  );

  // Handshakes depend on registered count only, so z_ready never reaches alu_ready.
  assign alu_ready = (count != 2'(DEPTH));
  assign z_valid   = (count != 2'd0);
  assign push      = alu_valid & alu_ready;
  assign pop       = z_valid & z_ready;

  always_comb begin
    new_entry      = '0;
    new_entry.lo   = alu_lo;
    new_entry.hi   = alu_wide ? alu_hi : '0;
    new_entry.wide = alu_wide;
    new_entry.zero = in_zero;
    new_entry.neg  = in_neg;
  end

  always_ff @(posedge clk) begin
    if (!clr || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries outside the occupied window are never shown.
  always_ff @(posedge clk) begin
    if (clr && !flush && push) mem[wr_ptr] <= new_entry;
  end

  assign head    = mem[rd_ptr];
  assign zlo_out = z_valid ? head.lo : '0;
  assign zhi_out = (z_valid && head.wide) ? head.hi : '0;
  assign z_zero  = z_valid & head.zero;
  assign z_neg   = z_valid & head.neg;
  assign z_count = count;

endmodule

// File: tb/tb_alu_z_stage.sv
// Scoreboard bench for alu_z_stage: expected entries are queued as results are
// driven and compared against the head of the buffer every cycle.
module tb_alu_z_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_lo;
  logic [31:0] alu_hi;
  logic        alu_wide;
  logic        flush;
  logic        z_valid;
  logic        z_ready;
  logic [31:0] zlo_out;
  logic [31:0] zhi_out;
  logic        z_zero;
  logic        z_neg;
  logic [1:0]  z_count;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        neg;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_z_stage dut (
    .clk       (clk),
    .clr       (clr),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_lo    (alu_lo),
    .alu_hi    (alu_hi),
    .alu_wide  (alu_wide),
    .flush     (flush),
    .z_valid   (z_valid),
    .z_ready   (z_ready),
    .zlo_out   (zlo_out),
    .zhi_out   (zhi_out),
    .z_zero    (z_zero),
    .z_neg     (z_neg),
    .z_count   (z_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs at the falling edge, advance the model.
  task automatic cycle(input logic v, input logic [31:0] lo, input logic [31:0] hi,
                       input logic w, input logic zr, input logic fl, input logic rst_n);
    exp_t e;
    int   n;
    logic push, pop;
    alu_valid = v;
    alu_lo    = lo;
    alu_hi    = hi;
    alu_wide  = w;
    z_ready   = zr;
    flush     = fl;
    clr       = rst_n;
    @(negedge clk);
    n = sb.size();
    chk("z_count",   64'(z_count),   64'(n));
    chk("z_valid",   64'(z_valid),   64'(n != 0));
    chk("alu_ready", 64'(alu_ready), 64'(n != 2));
    if (n != 0) begin
      chk("zlo_out", 64'(zlo_out), 64'(sb[0].lo));
      chk("zhi_out", 64'(zhi_out), 64'(sb[0].hi));
      chk("z_zero",  64'(z_zero),  64'(sb[0].zero));
      chk("z_neg",   64'(z_neg),   64'(sb[0].neg));
    end else begin
      chk("empty_outs", {zlo_out, zhi_out}, 64'h0);
      chk("empty_flags", 64'({z_zero, z_neg}), 64'h0);
    end
    push = v && (n != 2);
    pop  = zr && (n != 0);
    if (!rst_n || fl) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        e.lo   = lo;
        e.hi   = w ? hi : 32'h0;
        e.zero = (lo == 32'h0) && (!w || hi == 32'h0);
        e.neg  = w ? hi[31] : lo[31];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [31:0] lo, input logic zr);
    cycle(1'b1, lo, 32'hA5A5_A5A5, 1'b0, zr, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic zr);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, zr, 1'b0, 1'b1);
  endtask

  initial begin
    clr = 1'b0; alu_valid = 1'b0; alu_lo = '0; alu_hi = '0; alu_wide = 1'b0;
    flush = 1'b0; z_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Rotate-style narrow result with sign bit set
    push_n(32'h8000_0001, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill, refuse a third push, then drain in order
    push_n(32'h1111_1111, 1'b0);
    push_n(32'h2222_2222, 1'b0);
    push_n(32'h3333_3333, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Streaming at count 1 with pointer wrap
    push_n(32'hA000_0000, 1'b0);
    for (int i = 0; i < 6; i++) push_n(32'hB000_0000 + 32'(i), 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Wide results and ignored high word on narrow
    cycle(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    cycle(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    cycle(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    cycle(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Flush beats push at count 2, and at count 1 where alu_ready is high
    push_n(32'hC000_0001, 1'b0);
    push_n(32'hC000_0002, 1'b0);
    cycle(1'b1, 32'hC000_0003, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    push_n(32'hC000_0004, 1'b0);
    cycle(1'b1, 32'hC000_0005, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b0);

    // Reset mid-operation with a pending pop, then recovery
    push_n(32'hD000_0001, 1'b0);
    push_n(32'hD000_0002, 1'b0);
    cycle(1'b1, 32'hD000_0003, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    push_n(32'h5A5A_5A5A, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] rl;
      logic [31:0] rh;
      rl = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      rh = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      cycle(1'($urandom_range(0, 1)), rl, rh, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 19) != 0));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_z_stage.md
# alu_z_stage

Result-capture stage directly downstream of the 32-bit ALU function units (rotate, shift, logic, add/sub, mul/div). It registers each ALU result into a two-entry Z buffer holding ZLow/ZHigh pairs, derives zero/negative flags per entry, and presents the oldest entry to the bus-drive logic over a valid/ready handshake. The buffer decouples ALU issue from bus read-out, so a rotate result can be captured while the previous result is still being driven.

## Interface
- WIDTH, 32, datapath width of each Z half
- DEPTH, 2, number of buffered result entries; fixed at 2 for this design
- clk  in  1  single clock, all state on rising edge
- clr  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  stage can accept a result
- alu_lo  in  WIDTH  low result word (rotate/shift/logic result, product low, quotient)
- alu_hi  in  WIDTH  high result word (product high, remainder); ignored when alu_wide=0
- alu_wide  in  1  result is 64-bit (mul/div)
- flush  in  1  discard all buffered entries
- z_valid  out  1  oldest entry available
- z_ready  in  1  consumer takes the oldest entry
- zlo_out  out  WIDTH  ZLow of oldest entry
- zhi_out  out  WIDTH  ZHigh of oldest entry
- z_zero  out  1  oldest entry equals zero
- z_neg  out  1  oldest entry is negative
- z_count  out  2  occupancy, 0..2

## Operation
- Push = alu_valid & alu_ready; pop = z_valid & z_ready.
- Storage: circular buffer of DEPTH entries, 1-bit write pointer, 1-bit read pointer, 2-bit count; pointers wrap 1->0.
- Entry contents: lo, hi, wide, zero, neg. On push with alu_wide=0, hi is stored as 0 and alu_hi is ignored.
- Flags are computed at push time from the incoming data:
  - zero = (alu_lo == 0) & (~alu_wide | alu_hi == 0)
  - neg = alu_wide ? alu_hi[WIDTH-1] : alu_lo[WIDTH-1]
- alu_ready = (count != DEPTH). There is no combinational path from z_ready to alu_ready; a full buffer refuses a push even when a pop happens in the same cycle.
- z_valid = (count != 0). zlo_out, zhi_out, z_zero and z_neg reflect the read-pointer entry. When empty, all four are driven to 0.
- Push and pop in the same cycle at count 1: count stays 1, both pointers advance, and FIFO order is preserved.
- Flush has priority over push and pop in the same cycle: pointers and count go to 0 and the pushed data is dropped. alu_ready stays combinationally high during flush when the buffer is not full; the dropped push is the ALU's responsibility.
- Results are passed through unmodified; no saturation or width conversion.

## Timing
- clr=0 at a clock edge: count=0 and pointers=0. On the following cycle z_valid=0, alu_ready=1, zlo_out=zhi_out=0, z_zero=z_neg=0, z_count=0. Stored data is don't-care.
- Reset applied mid-operation discards all entries, with the same response as flush.
- Latency: a push at edge N gives z_valid=1 with that data after edge N, so it can be popped at edge N+1. Empty-to-valid is 1 cycle; there is no bypass.
- A pop at edge N presents the next entry, or z_valid=0, after edge N.
- alu_ready and z_valid are functions of registered count only.

## Structure
- Shared package alu_pkg:
  - WIDTH and DEPTH constants
  - z_entry_t struct {lo, hi, wide, zero, neg}
  - flag function or constants reused by the condition-code logic
- Sub-module z_flag_gen: combinational; inputs lo, hi, wide; outputs zero, neg. Instantiated once on the push path.
- Top level holds the entry array, pointers, count and handshake logic.

## Test plan
- Rotate result: push lo=0x80000001, wide=0, z_ready=0 -> next cycle z_valid=1, zlo_out=0x80000001, zhi_out=0, z_neg=1, z_zero=0, z_count=1.
- Full buffer: push 0x11111111 then 0x22222222 with z_ready=0 -> alu_ready=0, and a third push of 0x33333333 is ignored. Then z_ready=1 -> pops return 0x11111111 then 0x22222222, then z_valid=0.
- Simultaneous push/pop at count 1, repeated for 6 cycles -> z_count stays 1, data leaves in push order, pointers wrap cleanly.
- Wide result: push wide=1, hi=0x00000000, lo=0x00000000 -> z_zero=1. Push wide=1, hi=0xFFFFFFFF, lo=0x00000001 -> z_neg=1, z_zero=0. Push wide=0, hi=0xDEADBEEF, lo=0 -> zhi_out=0, z_zero=1.
- Flush with simultaneous push at count 2 -> next cycle z_count=0, z_valid=0, alu_ready=1, and the pushed data is absent.
- clr=0 asserted with count=2 while a pop is pending -> next cycle all outputs at reset values; with clr=1, the first push afterwards appears at zlo_out one cycle later.
